// File: rtl/ide_data_xfer_ctrl.sv
// rtl/ide_data_xfer_ctrl.sv - IDE PIO data-register transfer sequencer (optional IDE_DATA_PREFETCH_EN)
module ide_data_xfer_ctrl #(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ide_dior_n,
    input  logic             ide_diow_n,
    input  logic             ide_cs_data,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic             pin_oe,
    output logic             pin_latch,
    input  logic             xfer_start,
    input  logic             xfer_dir,
    input  logic [15:0]      xfer_len,
    input  logic             xfer_abort,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             busy,
    output logic             done,
    output logic             underrun,
    output logic             overrun
);

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_STROBE,
        WR_WAIT,
        WR_STROBE
    } state_t;

    state_t state;
    logic [15:0] remaining;

    logic [SYNC_STAGES-1:0] dior_sr;
    logic [SYNC_STAGES-1:0] diow_sr;
    logic [SYNC_STAGES-1:0] cs_sr;
    logic dior_q;
    logic diow_q;

    logic dior_s;
    logic diow_s;
    logic cs_s;
    logic rd_event;
    logic wr_fall;
    logic wr_event;

`ifdef IDE_DATA_PREFETCH_EN
    logic held;
`endif

    // Strobes idle high, so their synchronisers reset to 1 to avoid a false edge after reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dior_sr <= '1;
            diow_sr <= '1;
            cs_sr   <= '0;
            dior_q  <= 1'b1;
            diow_q  <= 1'b1;
        end else begin
            dior_sr <= {dior_sr[SYNC_STAGES-2:0], ide_dior_n};
            diow_sr <= {diow_sr[SYNC_STAGES-2:0], ide_diow_n};
            cs_sr   <= {cs_sr[SYNC_STAGES-2:0], ide_cs_data};
            dior_q  <= dior_sr[SYNC_STAGES-1];
            diow_q  <= diow_sr[SYNC_STAGES-1];
        end
    end

    assign dior_s   = dior_sr[SYNC_STAGES-1];
    assign diow_s   = diow_sr[SYNC_STAGES-1];
    assign cs_s     = cs_sr[SYNC_STAGES-1];
    assign rd_event = dior_q & ~dior_s & cs_s;
    assign wr_fall  = diow_q & ~diow_s & cs_s;
    assign wr_event = ~diow_q & diow_s & cs_s;

    // The pin cell holds its input while DIOW- is high, freezing write data at the host's rising edge
    assign pin_latch = ide_diow_n;

`ifdef IDE_DATA_PREFETCH_EN
    assign tx_ready = (state == RD_WAIT) && !held && tx_valid && !xfer_abort;
`else
    assign tx_ready = (state == RD_WAIT) && rd_event && !xfer_abort;
`endif

    // Transfer sequencer: word counting, pin drive, RX capture and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            remaining <= '0;
            pin_out   <= '0;
            pin_oe    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
            overrun   <= 1'b0;
`ifdef IDE_DATA_PREFETCH_EN
            held      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            if (xfer_abort) begin
                state  <= IDLE;
                pin_oe <= 1'b0;
                busy   <= 1'b0;
`ifdef IDE_DATA_PREFETCH_EN
                held   <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (xfer_start) begin
                            remaining <= xfer_len;
                            underrun  <= 1'b0;
                            overrun   <= 1'b0;
                            if (xfer_len == 16'd0) begin
                                done <= 1'b1;
                            end else begin
                                busy  <= 1'b1;
                                state <= xfer_dir ? RD_WAIT : WR_WAIT;
                            end
                        end
                    end
                    RD_WAIT: begin
`ifdef IDE_DATA_PREFETCH_EN
                        if (tx_ready) begin
                            pin_out <= tx_data;
                            held    <= 1'b1;
                        end
                        if (rd_event) begin
                            state  <= RD_STROBE;
                            pin_oe <= 1'b1;
                            if (!held && !tx_valid) begin
                                pin_out  <= '1;
                                underrun <= 1'b1;
                            end
                        end
`else
                        if (rd_event) begin
                            state  <= RD_STROBE;
                            pin_oe <= 1'b1;
                            if (tx_valid) begin
                                pin_out <= tx_data;
                            end else begin
                                pin_out  <= '1;
                                underrun <= 1'b1;
                            end
                        end
`endif
                    end
                    RD_STROBE: begin
                        if (dior_s) begin
                            pin_oe    <= 1'b0;
                            remaining <= remaining - 16'd1;
`ifdef IDE_DATA_PREFETCH_EN
                            held      <= 1'b0;
`endif
                            if (remaining == 16'd1) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                state <= RD_WAIT;
                            end
                        end
                    end
                    WR_WAIT: begin
                        if (wr_fall) begin
                            state <= WR_STROBE;
                        end
                    end
                    WR_STROBE: begin
                        if (wr_event) begin
                            if (rx_valid && !rx_ready) begin
                                overrun <= 1'b1;
                            end else begin
                                rx_data  <= pin_in;
                                rx_valid <= 1'b1;
                            end
                            remaining <= remaining - 16'd1;
                            if (remaining == 16'd1) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end else begin
                                state <= WR_WAIT;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ide_data_xfer_ctrl.sv
// tb/tb_ide_data_xfer_ctrl.sv - self-checking bench for ide_data_xfer_ctrl
module tb_ide_data_xfer_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ide_dior_n = 1'b1;
    logic        ide_diow_n = 1'b1;
    logic        ide_cs_data = 1'b0;
    logic [15:0] pin_in = '0;
    logic [15:0] pin_out;
    logic        pin_oe;
    logic        pin_latch;
    logic        xfer_start = 1'b0;
    logic        xfer_dir = 1'b0;
    logic [15:0] xfer_len = '0;
    logic        xfer_abort = 1'b0;
    logic [15:0] tx_data = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        underrun;
    logic        overrun;

    ide_data_xfer_ctrl #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .ide_dior_n(ide_dior_n), .ide_diow_n(ide_diow_n), .ide_cs_data(ide_cs_data),
        .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe), .pin_latch(pin_latch),
        .xfer_start(xfer_start), .xfer_dir(xfer_dir), .xfer_len(xfer_len), .xfer_abort(xfer_abort),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .done(done), .underrun(underrun), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Model state: what the TX source offers, what the host must see, what the sink must receive
    logic [15:0] txq[$];
    logic [15:0] exp_rd[$];
    logic [15:0] exp_rx[$];
    int tx_hs = 0;
    int tx_popped = 0;
    int done_cnt = 0;
    int oe_rise_cnt = 0;
    int rx_hs_cnt = 0;

    // TX source: counts handshakes mid-cycle, retires them just after the edge
    always @(negedge clk) if (tx_valid && tx_ready) tx_hs++;
    always @(posedge clk) begin
        #1;
        while (tx_popped < tx_hs) begin
            void'(txq.pop_front());
            tx_popped++;
        end
        tx_valid = (txq.size() > 0);
        tx_data  = (txq.size() > 0) ? txq[0] : 16'h0000;
    end

    // Per-cycle compare against the model
    logic        prev_oe = 1'b0;
    logic        prev_done = 1'b0;
    logic        prev_txr = 1'b0;
    logic [15:0] prev_out = '0;
    always @(negedge clk) begin
        logic [15:0] e;
        chk("pin_latch", {31'b0, pin_latch}, {31'b0, ide_diow_n});
        if (pin_oe) chk("oe_implies_busy", {31'b0, busy}, 32'd1);
        if (pin_oe && !prev_oe) begin
            oe_rise_cnt++;
            chk("rd_expected", exp_rd.size() > 0, 32'd1);
            if (exp_rd.size() > 0) begin
                e = exp_rd.pop_front();
                chk("rd_word", {16'b0, pin_out}, {16'b0, e});
            end
        end
        if (pin_oe && prev_oe) chk("pin_out_stable", {16'b0, pin_out}, {16'b0, prev_out});
        if (rx_valid && rx_ready) begin
            rx_hs_cnt++;
            chk("rx_expected", exp_rx.size() > 0, 32'd1);
            if (exp_rx.size() > 0) begin
                e = exp_rx.pop_front();
                chk("rx_word", {16'b0, rx_data}, {16'b0, e});
            end
        end
        if (done) begin
            done_cnt++;
            chk("done_busy_low", {31'b0, busy}, 32'd0);
            chk("done_one_cycle", {31'b0, prev_done}, 32'd0);
        end
        if (tx_ready) chk("tx_ready_one_cycle", {31'b0, prev_txr}, 32'd0);
        prev_oe   = pin_oe;
        prev_done = done;
        prev_txr  = tx_ready;
        prev_out  = pin_out;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input logic dir, input logic [15:0] len);
        xfer_dir   = dir;
        xfer_len   = len;
        xfer_start = 1'b1;
        cyc(1);
        xfer_start = 1'b0;
    endtask

    task automatic host_read;
        ide_cs_data = 1'b1;
        ide_dior_n  = 1'b0;
        cyc(8);
        ide_dior_n  = 1'b1;
        cyc(6);
        ide_cs_data = 1'b0;
        cyc(2);
    endtask

    task automatic host_write(input logic [15:0] v);
        ide_cs_data = 1'b1;
        pin_in      = v;
        ide_diow_n  = 1'b0;
        cyc(8);
        ide_diow_n  = 1'b1;
        cyc(6);
        ide_cs_data = 1'b0;
        cyc(2);
    endtask

    int d0, o0, r0;
    logic found;

    initial begin
        // Reset values
        #1 rst = 1'b1;
        #2;
        chk("rst_pin_out", {16'b0, pin_out}, 32'd0);
        chk("rst_pin_oe", {31'b0, pin_oe}, 32'd0);
        chk("rst_tx_ready", {31'b0, tx_ready}, 32'd0);
        chk("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
        chk("rst_rx_data", {16'b0, rx_data}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_flags", {30'b0, underrun, overrun}, 32'd0);
        cyc(3);
        rst = 1'b0;
        cyc(2);

        // Reset asserted while the read strobe is being served
        exp_rd.push_back(16'hFFFF);
        start(1'b1, 16'd1);
        ide_cs_data = 1'b1;
        ide_dior_n  = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (pin_oe) found = 1'b1;
        end
        chk("midrst_oe_seen", {31'b0, found}, 32'd1);
        chk("midrst_pre_underrun", {31'b0, underrun}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_oe", {31'b0, pin_oe}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_flags", {29'b0, underrun, overrun, done}, 32'd0);
        ide_dior_n  = 1'b1;
        ide_cs_data = 1'b0;
        cyc(4);
        rst = 1'b0;
        cyc(2);

        // Read of three words, all supplied
        d0 = done_cnt; o0 = oe_rise_cnt;
        txq.push_back(16'h1234); txq.push_back(16'hABCD); txq.push_back(16'h0001);
        exp_rd.push_back(16'h1234); exp_rd.push_back(16'hABCD); exp_rd.push_back(16'h0001);
        cyc(1);
        start(1'b1, 16'd3);
        chk("rd3_busy", {31'b0, busy}, 32'd1);
        for (int i = 0; i < 3; i++) host_read();
        chk("rd3_oe_pulses", oe_rise_cnt - o0, 32'd3);
        chk("rd3_done", done_cnt - d0, 32'd1);
        chk("rd3_busy_end", {31'b0, busy}, 32'd0);
        chk("rd3_underrun", {31'b0, underrun}, 32'd0);
        chk("rd3_tx_drained", txq.size(), 32'd0);

        // Read of two words with only one supplied
        d0 = done_cnt;
        txq.push_back(16'h7777);
        exp_rd.push_back(16'h7777); exp_rd.push_back(16'hFFFF);
        cyc(1);
        start(1'b1, 16'd2);
        host_read();
        chk("rd2_underrun_first", {31'b0, underrun}, 32'd0);
        host_read();
        chk("rd2_last_word", {16'b0, pin_out}, 32'h0000FFFF);
        chk("rd2_underrun", {31'b0, underrun}, 32'd1);
        chk("rd2_done", done_cnt - d0, 32'd1);

        // Write of two words, sink always ready
        d0 = done_cnt; r0 = rx_hs_cnt;
        rx_ready = 1'b1;
        exp_rx.push_back(16'h5A5A); exp_rx.push_back(16'hC3C3);
        start(1'b0, 16'd2);
        chk("wr_underrun_cleared", {31'b0, underrun}, 32'd0);
        host_write(16'h5A5A);
        host_write(16'hC3C3);
        chk("wr_rx_handshakes", rx_hs_cnt - r0, 32'd2);
        chk("wr_overrun", {31'b0, overrun}, 32'd0);
        chk("wr_done", done_cnt - d0, 32'd1);

        // Write of two words, sink never ready
        d0 = done_cnt; r0 = rx_hs_cnt;
        rx_ready = 1'b0;
        exp_rx.push_back(16'h5A5A);
        start(1'b0, 16'd2);
        host_write(16'h5A5A);
        host_write(16'hC3C3);
        chk("ovr_rx_data", {16'b0, rx_data}, 32'h00005A5A);
        chk("ovr_rx_valid", {31'b0, rx_valid}, 32'd1);
        chk("ovr_overrun", {31'b0, overrun}, 32'd1);
        chk("ovr_done", done_cnt - d0, 32'd1);
        rx_ready = 1'b1;
        cyc(3);
        chk("ovr_drain", rx_hs_cnt - r0, 32'd1);
        chk("ovr_rx_valid_clear", {31'b0, rx_valid}, 32'd0);

        // Zero-length transfer
        d0 = done_cnt;
        start(1'b1, 16'd0);
        @(negedge clk);
        chk("len0_done", {31'b0, done}, 32'd1);
        chk("len0_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        chk("len0_done_gone", {31'b0, done}, 32'd0);
        chk("len0_busy_still", {31'b0, busy}, 32'd0);
        cyc(1);
        chk("len0_done_cnt", done_cnt - d0, 32'd1);

        // Abort while waiting for a read strobe
        d0 = done_cnt; o0 = oe_rise_cnt;
        start(1'b1, 16'd2);
        cyc(3);
        xfer_abort = 1'b1;
        cyc(1);
        xfer_abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        cyc(1);
        host_read();
        chk("abort_no_oe", oe_rise_cnt - o0, 32'd0);
        chk("abort_no_done", done_cnt - d0, 32'd0);

        chk("rd_model_empty", exp_rd.size(), 32'd0);
        chk("rx_model_empty", exp_rx.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
